// File: rtl/text_grid_pkg.sv
// Shared definitions for the text grid editor: command codes, FSM states and
// the cursor move operations the FSM hands to the cursor block.
package text_grid_pkg;

   localparam logic [7:0] KEY_LEFT      = 8'h11;
   localparam logic [7:0] KEY_UP        = 8'h12;
   localparam logic [7:0] KEY_DOWN      = 8'h13;
   localparam logic [7:0] KEY_RIGHT     = 8'h14;
   localparam logic [7:0] KEY_ENTER     = 8'h0D;
   localparam logic [7:0] KEY_BS        = 8'h7F;
   localparam logic [7:0] KEY_CLR       = 8'h0C;
   localparam logic [7:0] CHAR_BLANK    = 8'h00;
   localparam logic [7:0] CHAR_PRINT_LO = 8'h20;
   localparam logic [7:0] CHAR_PRINT_HI = 8'h7E;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_CLEAR,
      ST_SCROLL_COPY,
      ST_SCROLL_FILL
   } state_t;

   typedef enum logic [2:0] {
      CUR_HOLD,
      CUR_NEXT,
      CUR_PREV,
      CUR_UP,
      CUR_DOWN,
      CUR_NEWLINE,
      CUR_HOME,
      CUR_LAST_ROW
   } cur_op_t;

endpackage

// File: rtl/text_grid_editor_if.sv
// Editing command stream into the text grid editor.
// Handshake: the master holds cmd_valid and the payload (cmd_char, cmd_fg,
// cmd_bg) stable until the slave samples cmd_valid && cmd_ready high on a
// rising clock edge; that edge is the single point where the command is taken.
interface text_grid_editor_if #(
   parameter int ASCII_W = 8,
   parameter int COLOR_W = 4
);
   logic               cmd_valid;
   logic               cmd_ready;
   logic [ASCII_W-1:0] cmd_char;
   logic [COLOR_W-1:0] cmd_fg;
   logic [COLOR_W-1:0] cmd_bg;

   modport master (output cmd_valid, cmd_char, cmd_fg, cmd_bg, input cmd_ready);
   modport slave  (input cmd_valid, cmd_char, cmd_fg, cmd_bg, output cmd_ready);
endinterface

// File: rtl/text_grid_cursor.sv
// Cursor position register for the text grid. Keeps the linear address and
// the column/row pair in step with each other using only add/compare, and
// flags the end-of-screen conditions the editor FSM needs.
module text_grid_cursor
   import text_grid_pkg::*;
#(
   parameter int GRID_COL = 10,
   parameter int GRID_ROW = 5
) (
   input  logic                                  clk_pix,
   input  logic                                  rst_n,
   input  cur_op_t                               i_op,
   output logic [$clog2(GRID_COL*GRID_ROW)-1:0]  o_addr,
   output logic [$clog2(GRID_COL)-1:0]           o_x,
   output logic [$clog2(GRID_ROW)-1:0]           o_y,
   output logic                                  o_at_end,
   output logic                                  o_at_zero,
   output logic                                  o_last_row
);
   localparam int AW = $clog2(GRID_COL*GRID_ROW);
   localparam int XW = $clog2(GRID_COL);
   localparam int YW = $clog2(GRID_ROW);
   localparam logic [AW-1:0] LAST_CELL     = AW'(GRID_COL*GRID_ROW-1);
   localparam logic [AW-1:0] LAST_ROW_BASE = AW'((GRID_ROW-1)*GRID_COL);
   localparam logic [AW-1:0] COL_STEP      = AW'(GRID_COL);
   localparam logic [XW-1:0] LAST_X        = XW'(GRID_COL-1);
   localparam logic [YW-1:0] LAST_Y        = YW'(GRID_ROW-1);

   logic [AW-1:0] r_addr, w_addr_n;
   logic [XW-1:0] r_x, w_x_n;
   logic [YW-1:0] r_y, w_y_n;

   // Next cursor position for the requested move, wrapping at grid edges.
   always_comb begin
      w_addr_n = r_addr;
      w_x_n    = r_x;
      w_y_n    = r_y;
      case (i_op)
         CUR_NEXT: begin
            if (r_addr == LAST_CELL) begin
               w_addr_n = '0; w_x_n = '0; w_y_n = '0;
            end else begin
               w_addr_n = r_addr + 1'b1;
               if (r_x == LAST_X) begin w_x_n = '0; w_y_n = r_y + 1'b1; end
               else w_x_n = r_x + 1'b1;
            end
         end
         CUR_PREV: begin
            if (r_addr == '0) begin
               w_addr_n = LAST_CELL; w_x_n = LAST_X; w_y_n = LAST_Y;
            end else begin
               w_addr_n = r_addr - 1'b1;
               if (r_x == '0) begin w_x_n = LAST_X; w_y_n = r_y - 1'b1; end
               else w_x_n = r_x - 1'b1;
            end
         end
         CUR_UP: begin
            if (r_y == '0) begin w_y_n = LAST_Y; w_addr_n = r_addr + LAST_ROW_BASE; end
            else begin w_y_n = r_y - 1'b1; w_addr_n = r_addr - COL_STEP; end
         end
         CUR_DOWN: begin
            if (r_y == LAST_Y) begin w_y_n = '0; w_addr_n = r_addr - LAST_ROW_BASE; end
            else begin w_y_n = r_y + 1'b1; w_addr_n = r_addr + COL_STEP; end
         end
         CUR_NEWLINE: begin
            w_x_n = '0;
            if (r_y == LAST_Y) begin w_y_n = '0; w_addr_n = '0; end
            else begin w_y_n = r_y + 1'b1; w_addr_n = r_addr - AW'(r_x) + COL_STEP; end
         end
         CUR_HOME: begin
            w_addr_n = '0; w_x_n = '0; w_y_n = '0;
         end
         CUR_LAST_ROW: begin
            w_addr_n = LAST_ROW_BASE; w_x_n = '0; w_y_n = LAST_Y;
         end
         default: ;
      endcase
   end

   // Cursor registers, cleared to cell 0 on reset.
   always_ff @(posedge clk_pix or negedge rst_n) begin
      if (!rst_n) begin
         r_addr <= '0;
         r_x    <= '0;
         r_y    <= '0;
      end else begin
         r_addr <= w_addr_n;
         r_x    <= w_x_n;
         r_y    <= w_y_n;
      end
   end

   assign o_addr     = r_addr;
   assign o_x        = r_x;
   assign o_y        = r_y;
   assign o_at_end   = (r_addr == LAST_CELL);
   assign o_at_zero  = (r_addr == '0);
   assign o_last_row = (r_y == LAST_Y);
endmodule

// File: rtl/text_grid_editor.sv
// Character grid editor: GRID_COL x GRID_ROW cells of {bg, fg, ascii}, edited
// through a valid/ready command stream, with a registered display read port.
// Clear, power-up fill and scroll run as one-cell-per-cycle sweeps.
// Optional cursor blink is enabled by defining TEXT_GRID_CURSOR_BLINK_EN.
module text_grid_editor
   import text_grid_pkg::*;
#(
   parameter int                GRID_COL     = 10,
   parameter int                GRID_ROW     = 5,
   parameter int                ASCII_W      = 8,
   parameter int                COLOR_W      = 4,
   parameter int                SCROLL_MODE  = 0,
   parameter logic [COLOR_W-1:0] DEF_FG      = 4'hC,
   parameter logic [COLOR_W-1:0] DEF_BG      = 4'h0,
   parameter int                BLINK_FRAMES = 30,
   localparam int N      = GRID_COL*GRID_ROW,
   localparam int ADDR_W = $clog2(N),
   localparam int CELL_W = 2*COLOR_W + ASCII_W
) (
   input  logic                        clk_pix,
   input  logic                        rst_n,
   text_grid_editor_if.slave           cmd,
   input  logic [ADDR_W-1:0]           rd_addr,
   output logic [CELL_W-1:0]           rd_data,
   output logic [ADDR_W-1:0]           cursor_addr,
   output logic [$clog2(GRID_COL)-1:0] cursor_x,
   output logic [$clog2(GRID_ROW)-1:0] cursor_y,
   output logic                        cursor_on,
   input  logic                        frame_tick,
   output logic                        busy,
   output state_t                      o_dbg_state
);
   localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(N-1);
   localparam logic [ADDR_W-1:0] COPY_LAST = ADDR_W'(N-GRID_COL-1);
   localparam logic [ADDR_W-1:0] COL_STEP  = ADDR_W'(GRID_COL);
   localparam logic [ADDR_W:0]   N_EXT     = (ADDR_W+1)'(N);
   localparam logic [ASCII_W-1:0] BLANK    = ASCII_W'(CHAR_BLANK);

   logic [CELL_W-1:0]  r_mem [N];
   state_t             r_state, w_state_n;
   logic [ADDR_W-1:0]  r_sweep_idx, w_sweep_idx_n;
   logic [COLOR_W-1:0] r_fill_fg, r_fill_bg;
   logic               w_accept, w_printable, w_we;
   logic [ADDR_W-1:0]  w_waddr;
   logic [CELL_W-1:0]  w_wdata;
   cur_op_t            w_cur_op;
   logic               w_at_end, w_at_zero, w_last_row;

   assign w_accept    = cmd.cmd_valid && (r_state == ST_IDLE);
   assign w_printable = (cmd.cmd_char >= ASCII_W'(CHAR_PRINT_LO)) &&
                        (cmd.cmd_char <= ASCII_W'(CHAR_PRINT_HI));
   assign cmd.cmd_ready = (r_state == ST_IDLE);
   assign busy          = (r_state != ST_IDLE);
   assign o_dbg_state   = r_state;

   text_grid_cursor #(.GRID_COL(GRID_COL), .GRID_ROW(GRID_ROW)) u_cursor (
      .clk_pix    (clk_pix),
      .rst_n      (rst_n),
      .i_op       (w_cur_op),
      .o_addr     (cursor_addr),
      .o_x        (cursor_x),
      .o_y        (cursor_y),
      .o_at_end   (w_at_end),
      .o_at_zero  (w_at_zero),
      .o_last_row (w_last_row)
   );

   // Sweep sequencing and command decode; produces the single grid write port.
   always_comb begin
      w_state_n     = r_state;
      w_sweep_idx_n = r_sweep_idx;
      w_we          = 1'b0;
      w_waddr       = r_sweep_idx;
      w_wdata       = '0;
      w_cur_op      = CUR_HOLD;
      case (r_state)
         ST_INIT, ST_CLEAR, ST_SCROLL_FILL: begin
            w_we    = 1'b1;
            w_wdata = (r_state == ST_INIT) ? {DEF_BG, DEF_FG, BLANK}
                                           : {r_fill_bg, r_fill_fg, BLANK};
            if (r_sweep_idx == LAST_CELL) begin
               w_state_n     = ST_IDLE;
               w_sweep_idx_n = '0;
            end else begin
               w_sweep_idx_n = r_sweep_idx + 1'b1;
            end
         end
         ST_SCROLL_COPY: begin
            w_we          = 1'b1;
            w_wdata       = r_mem[r_sweep_idx + COL_STEP];
            w_sweep_idx_n = r_sweep_idx + 1'b1;
            if (r_sweep_idx == COPY_LAST) w_state_n = ST_SCROLL_FILL;
         end
         ST_IDLE: begin
            if (w_accept) begin
               if (w_printable) begin
                  w_we    = 1'b1;
                  w_waddr = cursor_addr;
                  w_wdata = {cmd.cmd_bg, cmd.cmd_fg, cmd.cmd_char};
                  if ((SCROLL_MODE != 0) && w_at_end) begin
                     w_cur_op      = CUR_LAST_ROW;
                     w_state_n     = ST_SCROLL_COPY;
                     w_sweep_idx_n = '0;
                  end else begin
                     w_cur_op = CUR_NEXT;
                  end
               end else begin
                  case (cmd.cmd_char)
                     ASCII_W'(KEY_LEFT):  w_cur_op = CUR_PREV;
                     ASCII_W'(KEY_RIGHT): w_cur_op = CUR_NEXT;
                     ASCII_W'(KEY_UP):    w_cur_op = CUR_UP;
                     ASCII_W'(KEY_DOWN):  w_cur_op = CUR_DOWN;
                     ASCII_W'(KEY_ENTER): begin
                        if ((SCROLL_MODE != 0) && w_last_row) begin
                           w_cur_op      = CUR_LAST_ROW;
                           w_state_n     = ST_SCROLL_COPY;
                           w_sweep_idx_n = '0;
                        end else begin
                           w_cur_op = CUR_NEWLINE;
                        end
                     end
                     ASCII_W'(KEY_BS): begin
                        if (!w_at_zero) begin
                           w_cur_op = CUR_PREV;
                           w_we     = 1'b1;
                           w_waddr  = cursor_addr - 1'b1;
                           w_wdata  = {cmd.cmd_bg, cmd.cmd_fg, BLANK};
                        end
                     end
                     ASCII_W'(KEY_CLR): begin
                        w_cur_op      = CUR_HOME;
                        w_state_n     = ST_CLEAR;
                        w_sweep_idx_n = '0;
                     end
                     default: ;
                  endcase
               end
            end
         end
         default: w_state_n = ST_INIT;
      endcase
   end

   // FSM state, sweep index and fill colours latched at each accepted command.
   always_ff @(posedge clk_pix or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_INIT;
         r_sweep_idx <= '0;
         r_fill_fg   <= '0;
         r_fill_bg   <= '0;
      end else begin
         r_state     <= w_state_n;
         r_sweep_idx <= w_sweep_idx_n;
         if (w_accept) begin
            r_fill_fg <= cmd.cmd_fg;
            r_fill_bg <= cmd.cmd_bg;
         end
      end
   end

   // Grid storage; contents are established by the INIT sweep, not by reset.
   always_ff @(posedge clk_pix) begin
      if (w_we) r_mem[w_waddr] <= w_wdata;
   end

   // Registered display read; a same-cycle write is seen on the next read.
   always_ff @(posedge clk_pix or negedge rst_n) begin
      if (!rst_n)                      rd_data <= '0;
      else if ({1'b0, rd_addr} < N_EXT) rd_data <= r_mem[rd_addr];
      else                             rd_data <= '0;
   end

`ifdef TEXT_GRID_CURSOR_BLINK_EN
   localparam int BLINK_CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [BLINK_CNT_W-1:0] BLINK_LAST = BLINK_CNT_W'(BLINK_FRAMES-1);
   logic [BLINK_CNT_W-1:0] r_blink_cnt;
   logic                   r_cursor_on;

   // Blink timer: toggle every BLINK_FRAMES frames, restart solid on any command.
   always_ff @(posedge clk_pix or negedge rst_n) begin
      if (!rst_n) begin
         r_blink_cnt <= '0;
         r_cursor_on <= 1'b1;
      end else if (w_accept) begin
         r_blink_cnt <= '0;
         r_cursor_on <= 1'b1;
      end else if (frame_tick) begin
         if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_cursor_on <= ~r_cursor_on;
         end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
         end
      end
   end

   assign cursor_on = r_cursor_on;
`else
   localparam int unused_blink_frames = BLINK_FRAMES;
   logic w_unused_frame_tick;
   assign w_unused_frame_tick = frame_tick;
   assign cursor_on = 1'b1;
`endif
endmodule

// File: tb/tb_text_grid_editor.sv
// Bench for text_grid_editor: one WRAP-mode and one SCROLL-mode instance,
// directed scenarios plus randomized command streams compared against a
// cell-array reference model.
module tb_text_grid_editor;
   localparam int COL = 10;
   localparam int ROW = 5;
   localparam int N   = COL*ROW;
   localparam int AW  = 6;
   localparam int CW  = 16;
   localparam int BF  = 2;

   logic clk_pix = 1'b0;
   logic rst_n;
   logic frame_tick;

   // Clock: 10 ns period.
   always #5 clk_pix = ~clk_pix;

   logic          tb_valid [2];
   logic [7:0]    tb_char  [2];
   logic [3:0]    tb_fg    [2];
   logic [3:0]    tb_bg    [2];
   logic          tb_ready [2];
   logic [AW-1:0] rd_addr  [2];
   logic [CW-1:0] rd_data  [2];
   logic [AW-1:0] cur_addr [2];
   logic [3:0]    cur_x    [2];
   logic [2:0]    cur_y    [2];
   logic          cur_on   [2];
   logic          busy     [2];
   text_grid_pkg::state_t dbg_state [2];

   text_grid_editor_if #(.ASCII_W(8), .COLOR_W(4)) cif_w ();
   text_grid_editor_if #(.ASCII_W(8), .COLOR_W(4)) cif_s ();

   assign cif_w.cmd_valid = tb_valid[0];
   assign cif_w.cmd_char  = tb_char[0];
   assign cif_w.cmd_fg    = tb_fg[0];
   assign cif_w.cmd_bg    = tb_bg[0];
   assign tb_ready[0]     = cif_w.cmd_ready;
   assign cif_s.cmd_valid = tb_valid[1];
   assign cif_s.cmd_char  = tb_char[1];
   assign cif_s.cmd_fg    = tb_fg[1];
   assign cif_s.cmd_bg    = tb_bg[1];
   assign tb_ready[1]     = cif_s.cmd_ready;

   text_grid_editor #(.SCROLL_MODE(0), .BLINK_FRAMES(BF)) u_wrap (
      .clk_pix(clk_pix), .rst_n(rst_n), .cmd(cif_w.slave),
      .rd_addr(rd_addr[0]), .rd_data(rd_data[0]), .cursor_addr(cur_addr[0]),
      .cursor_x(cur_x[0]), .cursor_y(cur_y[0]), .cursor_on(cur_on[0]),
      .frame_tick(frame_tick), .busy(busy[0]), .o_dbg_state(dbg_state[0])
   );

   text_grid_editor #(.SCROLL_MODE(1), .BLINK_FRAMES(BF)) u_scroll (
      .clk_pix(clk_pix), .rst_n(rst_n), .cmd(cif_s.slave),
      .rd_addr(rd_addr[1]), .rd_data(rd_data[1]), .cursor_addr(cur_addr[1]),
      .cursor_x(cur_x[1]), .cursor_y(cur_y[1]), .cursor_on(cur_on[1]),
      .frame_tick(frame_tick), .busy(busy[1]), .o_dbg_state(dbg_state[1])
   );

   // Reference model state.
   logic [CW-1:0] mdl_mem [2][N];
   int            mdl_cur   [2];
   int            mdl_ticks [2];
   int            n_checks = 0;
   int            n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic exp_on(input int sel);
`ifdef TEXT_GRID_CURSOR_BLINK_EN
      return ((mdl_ticks[sel] / BF) % 2) == 0;
`else
      return (mdl_ticks[sel] >= 0);
`endif
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < N; i++) mdl_mem[s][i] = 16'h0C00;
         mdl_cur[s]   = 0;
         mdl_ticks[s] = 0;
      end
   endtask

   task automatic model_scroll(input int sel, input logic [3:0] fg, input logic [3:0] bg);
      for (int i = 0; i < N-COL; i++) mdl_mem[sel][i] = mdl_mem[sel][i+COL];
      for (int i = N-COL; i < N; i++) mdl_mem[sel][i] = {bg, fg, 8'h00};
   endtask

   task automatic model_cmd(input int sel, input logic [7:0] ch, input logic [3:0] fg,
                            input logic [3:0] bg, output bit sweep);
      int c = mdl_cur[sel];
      bit scroll = (sel == 1);
      sweep = 0;
      if (ch >= 8'h20 && ch <= 8'h7E) begin
         mdl_mem[sel][c] = {bg, fg, ch};
         if (c == N-1) begin
            if (scroll) begin model_scroll(sel, fg, bg); c = (ROW-1)*COL; sweep = 1; end
            else c = 0;
         end else c = c + 1;
      end else begin
         case (ch)
            8'h11: c = (c + N - 1) % N;
            8'h14: c = (c + 1) % N;
            8'h12: c = (c + N - COL) % N;
            8'h13: c = (c + COL) % N;
            8'h0D: begin
               if (c / COL == ROW-1) begin
                  if (scroll) begin model_scroll(sel, fg, bg); c = (ROW-1)*COL; sweep = 1; end
                  else c = 0;
               end else c = (c / COL + 1) * COL;
            end
            8'h7F: if (c > 0) begin c = c - 1; mdl_mem[sel][c] = {bg, fg, 8'h00}; end
            8'h0C: begin
               for (int i = 0; i < N; i++) mdl_mem[sel][i] = {bg, fg, 8'h00};
               c = 0;
               sweep = 1;
            end
            default: ;
         endcase
      end
      mdl_cur[sel] = c;
   endtask

   // Driver: present one command, hold it until accepted, update the model.
   task automatic send(input int sel, input logic [7:0] ch, input logic [3:0] fg,
                       input logic [3:0] bg, output bit sweep);
      int guard = 0;
      @(negedge clk_pix);
      tb_valid[sel] = 1'b1;
      tb_char[sel]  = ch;
      tb_fg[sel]    = fg;
      tb_bg[sel]    = bg;
      while (!tb_ready[sel] && guard < 200) begin
         @(negedge clk_pix);
         guard++;
      end
      check($sformatf("cmd_ready%0d", sel), tb_ready[sel], 1);
      @(negedge clk_pix);
      tb_valid[sel] = 1'b0;
      model_cmd(sel, ch, fg, bg, sweep);
      mdl_ticks[sel] = 0;
   endtask

   task automatic wait_sweep(input int sel, input string tag);
      int cnt = 0;
      while (busy[sel] && cnt < 200) begin
         cnt++;
         @(negedge clk_pix);
      end
      check(tag, cnt, N);
   endtask

   task automatic check_cursor(input int sel);
      check($sformatf("cur_addr%0d", sel), cur_addr[sel], mdl_cur[sel]);
      check($sformatf("cur_x%0d", sel), cur_x[sel], mdl_cur[sel] % COL);
      check($sformatf("cur_y%0d", sel), cur_y[sel], mdl_cur[sel] / COL);
      check($sformatf("cur_on%0d", sel), cur_on[sel], exp_on(sel));
   endtask

   task automatic do_cmd(input int sel, input logic [7:0] ch, input logic [3:0] fg, input logic [3:0] bg);
      bit sweep;
      send(sel, ch, fg, bg, sweep);
      if (sweep) wait_sweep(sel, $sformatf("sweep_len%0d", sel));
      else check($sformatf("busy_idle%0d", sel), busy[sel], 0);
      check_cursor(sel);
   endtask

   task automatic read_cell(input int sel, input int addr, output logic [CW-1:0] data);
      @(negedge clk_pix);
      rd_addr[sel] = AW'(addr);
      @(negedge clk_pix);
      data = rd_data[sel];
   endtask

   task automatic check_cell(input int sel, input int addr);
      logic [CW-1:0] d;
      read_cell(sel, addr, d);
      check($sformatf("cell%0d_%0d", sel, addr), d, mdl_mem[sel][addr]);
   endtask

   task automatic check_grid(input int sel);
      for (int i = 0; i < N; i++) check_cell(sel, i);
   endtask

   task automatic check_reset_outputs(input string tag);
      for (int s = 0; s < 2; s++) begin
         check($sformatf("%s_ready%0d", tag, s), tb_ready[s], 0);
         check($sformatf("%s_busy%0d", tag, s), busy[s], 1);
         check($sformatf("%s_rd%0d", tag, s), rd_data[s], 0);
         check($sformatf("%s_cur%0d", tag, s), cur_addr[s], 0);
         check($sformatf("%s_x%0d", tag, s), cur_x[s], 0);
         check($sformatf("%s_y%0d", tag, s), cur_y[s], 0);
         check($sformatf("%s_on%0d", tag, s), cur_on[s], 1);
      end
   endtask

   // Release reset with commands pending and measure the INIT sweep.
   task automatic release_and_init(input string tag);
      int cnt = 0;
      int bad = 0;
      @(negedge clk_pix);
      tb_valid[0] = 1'b1; tb_char[0] = 8'h00;
      tb_valid[1] = 1'b1; tb_char[1] = 8'h00;
      rst_n = 1'b1;
      model_reset();
      while (busy[0] && cnt < 200) begin
         if (tb_ready[0] || tb_ready[1]) bad++;
         cnt++;
         @(negedge clk_pix);
      end
      tb_valid[0] = 1'b0;
      tb_valid[1] = 1'b0;
      check({tag, "_busy_cycles"}, cnt, N);
      check({tag, "_ready_low"}, bad, 0);
      check({tag, "_scroll_idle"}, busy[1], 0);
   endtask

   task automatic pulse_frames(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk_pix);
         frame_tick = 1'b1;
         @(negedge clk_pix);
         frame_tick = 1'b0;
         mdl_ticks[0]++;
         mdl_ticks[1]++;
         check("blink_on0", cur_on[0], exp_on(0));
         check("blink_on1", cur_on[1], exp_on(1));
      end
   endtask

   function automatic logic [7:0] rand_code();
      logic [7:0] others [6];
      int k;
      others[0] = 8'h00; others[1] = 8'h01; others[2] = 8'h0A;
      others[3] = 8'h1B; others[4] = 8'h80; others[5] = 8'hFF;
      k = $urandom_range(0, 19);
      case (k)
         10: return 8'h11;
         11: return 8'h14;
         12: return 8'h12;
         13: return 8'h13;
         14: return 8'h0D;
         15: return 8'h7F;
         16: return ($urandom_range(0, 3) == 0) ? 8'h0C : 8'h14;
         17: return others[$urandom_range(0, 5)];
         default: return 8'($urandom_range(8'h20, 8'h7E));
      endcase
   endfunction

   // Watchdog: the run must end on its own.
   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Main sequence.
   initial begin
      logic [CW-1:0] d;
      bit sw;
      rst_n = 1'b0;
      frame_tick = 1'b0;
      for (int s = 0; s < 2; s++) begin
         tb_valid[s] = 1'b0; tb_char[s] = 8'h00; tb_fg[s] = 4'h0; tb_bg[s] = 4'h0;
         rd_addr[s] = '0;
      end
      model_reset();
      repeat (3) @(negedge clk_pix);
      check_reset_outputs("rst");

      // Power-up INIT sweep and default contents.
      release_and_init("init");
      check_grid(0);
      check_grid(1);
      check_cursor(0);
      check_cursor(1);

      // Out-of-range read addresses return zero.
      read_cell(0, 55, d); check("rd_oob55", d, 0);
      read_cell(0, 63, d); check("rd_oob63", d, 0);

      // First write and read-back.
      do_cmd(0, 8'h41, 4'h3, 4'h1);
      check("t2_cursor", cur_addr[0], 1);
      read_cell(0, 0, d); check("t2_cell0", d, 16'h1341);

      // WRAP-mode boundaries.
      do_cmd(0, 8'h11, 4'h0, 4'h0);
      do_cmd(0, 8'h11, 4'h0, 4'h0);
      check("t3_left_wrap", cur_addr[0], 49);
      do_cmd(0, 8'h5A, 4'h2, 4'h5);
      check("t3_write_wrap", cur_addr[0], 0);
      read_cell(0, 49, d); check("t3_cell49", d, 16'h525A);
      do_cmd(0, 8'h11, 4'h0, 4'h0);
      check("t3_left0", cur_addr[0], 49);
      do_cmd(0, 8'h14, 4'h0, 4'h0);
      for (int i = 0; i < 3; i++) do_cmd(0, 8'h14, 4'h0, 4'h0);
      do_cmd(0, 8'h12, 4'h0, 4'h0);
      check("t3_up3", cur_addr[0], 43);

      // SCROLL mode: fill rows, enter on the last row.
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < COL; c++) do_cmd(1, 8'h30 + 8'(r), 4'h7, 4'h2);
      for (int c = 0; c < COL-1; c++) do_cmd(1, 8'h34, 4'h7, 4'h2);
      for (int c = 0; c < COL-1; c++) do_cmd(1, 8'h11, 4'h7, 4'h2);
      check("t4_pre_cursor", cur_addr[1], 40);
      do_cmd(1, 8'h0D, 4'h1, 4'h3);
      check("t4_cursor", cur_addr[1], 40);
      read_cell(1, 0, d);  check("t4_row0", d, 16'h2731);
      read_cell(1, 30, d); check("t4_row3", d, 16'h2734);
      read_cell(1, 45, d); check("t4_row4", d, 16'h3100);
      check_grid(1);

      // Backspace boundaries after a clear.
      do_cmd(0, 8'h0C, 4'h6, 4'h0);
      do_cmd(0, 8'h7F, 4'h9, 4'h4);
      check("t5_bs0_cursor", cur_addr[0], 0);
      read_cell(0, 0, d); check("t5_bs0_cell", d, 16'h0600);
      do_cmd(0, 8'h13, 4'h0, 4'h0);
      do_cmd(0, 8'h14, 4'h0, 4'h0);
      do_cmd(0, 8'h14, 4'h0, 4'h0);
      do_cmd(0, 8'h7F, 4'h9, 4'h4);
      check("t5_bs12_cursor", cur_addr[0], 11);
      read_cell(0, 11, d); check("t5_bs12_cell", d, 16'h4900);

      // Randomized command streams on both modes.
      for (int s = 0; s < 2; s++) begin
         for (int k = 0; k < 80; k++) begin
            do_cmd(s, rand_code(), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            if (k % 4 == 3) check_cell(s, $urandom_range(0, N-1));
         end
         check_grid(s);
      end

      // Frame ticks drive the blink only when the feature is built in.
      pulse_frames(5);
      do_cmd(0, 8'h01, 4'h0, 4'h0);
      pulse_frames(3);

      // Reset in the middle of a clear sweep.
      send(0, 8'h0C, 4'h5, 4'h5, sw);
      repeat (20) @(negedge clk_pix);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      release_and_init("reinit");
      check_grid(0);
      check_cursor(0);
      check_cursor(1);
      pulse_frames(4);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/text_grid_editor.md
Name: text_grid_editor

Overview:
Parametrised successor to the typewriter display buffer. Holds a GRID_COL x GRID_ROW character grid of {bg, fg, ascii} cells and accepts editing commands over a valid/ready stream. Provides a registered pixel-side read port and reports the cursor position as separate outputs; the cursor is not stored in the grid. Supports WRAP or SCROLL end-of-screen mode, and uses multi-cycle sweeps for clear and scroll.

Parameters:
GRID_COL, 10, columns per row
GRID_ROW, 5, rows
ASCII_W, 8, character code width
COLOR_W, 4, CLUT index width, per colour
SCROLL_MODE, 0, 0 = cursor wraps to cell 0 at end of screen; 1 = grid scrolls up one row
DEF_FG, 4'hC, foreground index used by the reset sweep
DEF_BG, 4'h0, background index used by the reset sweep
BLINK_FRAMES, 30, frame ticks per cursor blink half-period (used only with the optional feature)

Ports:
clk_pix  in  1  pixel clock; the only clock
rst_n  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_char  in  ASCII_W  character or control code
cmd_fg  in  COLOR_W  foreground index for written cells
cmd_bg  in  COLOR_W  background index for written and cleared cells
rd_addr  in  ADDR_W  display read address, ADDR_W = $clog2(GRID_COL*GRID_ROW)
rd_data  out  CELL_W  cell {bg, fg, ascii}, CELL_W = 2*COLOR_W + ASCII_W
cursor_addr  out  ADDR_W  linear cursor index
cursor_x  out  $clog2(GRID_COL)  cursor column
cursor_y  out  $clog2(GRID_ROW)  cursor row
cursor_on  out  1  cursor visible this frame
frame_tick  in  1  one-cycle pulse per frame
busy  out  1  sweep in progress

Behaviour:
- Reset values: cmd_ready=0, busy=1, rd_data=0, cursor_addr/x/y=0, cursor_on=1. FSM enters INIT.
- FSM states: INIT, IDLE, CLEAR, SCROLL_COPY, SCROLL_FILL.
- cmd_ready=1 only in IDLE. busy = !(state==IDLE).
- INIT: writes {DEF_BG, DEF_FG, 0x00} to one cell per cycle, addresses 0..N-1 (N = GRID_COL*GRID_ROW). Takes N cycles, then goes to IDLE.
- Commands are accepted in IDLE only. Effects below are visible from the cycle after the handshake.
- 0x20..0x7E (printable):
  - Write {cmd_bg, cmd_fg, cmd_char} at the cursor, then advance the cursor by 1.
  - At cell N-1: WRAP mode moves the cursor to 0.
  - At cell N-1: SCROLL mode enters SCROLL_COPY, and the cursor becomes (GRID_ROW-1)*GRID_COL.
- 0x11 left / 0x14 right: cursor -/+1, wrapping linearly 0 <-> N-1 in both modes.
- 0x12 up / 0x13 down: cursor -/+GRID_COL, wrapping within the same column in both modes.
- 0x0D enter: cursor moves to the start of the next row.
  - On the last row: WRAP mode goes to 0; SCROLL mode scrolls, and the cursor becomes the start of the last row.
- 0x7F backspace: if cursor > 0, the cursor is decremented and the new cell is written {cmd_bg, cmd_fg, 0x00}. At 0 it is a no-op.
- 0x0C clear: enters CLEAR, filling all cells with {cmd_bg, cmd_fg, 0x00} (colours latched at handshake), 1 cell/cycle over N cycles. The cursor becomes 0.
- All other codes are consumed with no effect.
- SCROLL_COPY: cell[i] <= cell[i+GRID_COL] for i = 0..N-GRID_COL-1, one cell per cycle.
- SCROLL_FILL: the last row is filled with {latched bg, latched fg, 0x00} over GRID_COL cycles, then the FSM returns to IDLE.
- Total scroll latency is N cycles.
- Read port: rd_data <= cell[rd_addr] with 1-cycle latency, served in every state.
  - Same-cycle read and write to one address returns the old value.
  - rd_addr >= N returns 0.
- Reset asserted mid-sweep aborts the sweep immediately and restarts INIT after release.
- cursor_x/y are maintained as registers consistent with cursor_addr. They are not derived by a divider.

Optional Feature:
Macro: TEXT_GRID_CURSOR_BLINK_EN.
- Defined: a counter increments on frame_tick. cursor_on toggles every BLINK_FRAMES ticks.
  - Any accepted command forces cursor_on=1 and resets the counter.
  - Reset sets cursor_on=1 and the counter to 0.
- Undefined: cursor_on is tied to 1, frame_tick is ignored, and no counter is synthesised.

Decomposition:
- Package text_grid_pkg holds:
  - Control-code localparams: KEY_LEFT=0x11, KEY_UP=0x12, KEY_DOWN=0x13, KEY_RIGHT=0x14, KEY_ENTER=0x0D, KEY_BS=0x7F, KEY_CLR=0x0C, CHAR_BLANK=0x00.
  - The FSM state enum.
- Natural sub-module: text_grid_cursor. It holds cursor_addr/x/y and the move/wrap arithmetic, and reports the end-of-screen condition to the FSM.
- The storage array and the FSM remain in text_grid_editor.

Test Plan:
1. Release reset, hold cmd_valid=1 -> busy=1 and cmd_ready=0 for exactly 50 cycles. Then every rd_data = {0x0, 0xC, 0x00} and the cursor = 0.
2. Write 'A' (0x41, fg=3, bg=1) at cursor 0 -> next cycle cursor_addr=1. rd_addr=0 returns 0x1341 one cycle later.
3. WRAP mode: cursor=49, write 'Z' -> cell 49 = 'Z', cursor=0. Left at 0 -> cursor=49. Up at 3 -> cursor=43.
4. SCROLL_MODE=1: fill rows with '0'..'4', cursor=40, send enter -> busy for 50 cycles. Afterwards row r holds digit r+1 (r=0..3), row 4 is blank, and cursor=40.
5. Backspace at 0 -> no write, cursor stays 0. Backspace at 12 -> cursor=11 and cell 11 ascii=0x00.
6. Send clear, then assert rst_n=0 after 20 sweep cycles -> outputs return to reset values. After release, INIT runs the full 50 cycles. With TEXT_GRID_CURSOR_BLINK_EN and BLINK_FRAMES=2, cursor_on toggles every 2 frame_tick pulses.
